// File: rtl/pipe_stage_skid_reg.sv
// Pipeline stage register with valid/ready handshake backed by a 2-entry skid buffer.
// Latency: 1 cycle from acceptance into an empty stage to out_valid; 1 entry/cycle sustained.
// Backpressure: in_ready depends only on registered state (~skid valid), never on out_ready.
//
// Ports: clock/reset (sync, active-high), flush (sync kill of held entries),
//   in_valid/in_ready/in_ctrl/in_dest/in_data   upstream side (word 0 in LSBs of in_data)
//   out_valid/out_ready/out_ctrl/out_dest/out_data downstream side (out_ctrl gated by out_valid)
// Optional macro PIPE_STAGE_PERF_EN adds saturating stall_cnt / bubble_cnt outputs.
module pipe_stage_skid_reg #(
    parameter int CTRL_W    = 4,
    parameter int DEST_W    = 5,
    parameter int DATA_W    = 32,
    parameter int NUM_WORDS = 2
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          flush,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [CTRL_W-1:0]             in_ctrl,
    input  logic [DEST_W-1:0]             in_dest,
    input  logic [NUM_WORDS*DATA_W-1:0]   in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [CTRL_W-1:0]             out_ctrl,
    output logic [DEST_W-1:0]             out_dest,
    output logic [NUM_WORDS*DATA_W-1:0]   out_data
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [15:0]                   stall_cnt,
    output logic [15:0]                   bubble_cnt
`endif
);

    typedef struct packed {
        logic [CTRL_W-1:0]           ctrl;
        logic [DEST_W-1:0]           dest;
        logic [NUM_WORDS*DATA_W-1:0] data;
    } entry_t;

    entry_t m_q, s_q, in_ent;
    logic   m_v, s_v;
    logic   up_fire, dn_fire;

    assign in_ent   = '{ctrl: in_ctrl, dest: in_dest, data: in_data};
    assign in_ready = ~s_v & ~reset;
    assign up_fire  = in_valid & in_ready;
    assign dn_fire  = m_v & out_ready;

    assign out_valid = m_v;
    // Bubbles must never carry live write enables downstream.
    assign out_ctrl  = m_q.ctrl & {CTRL_W{m_v}};
    assign out_dest  = m_q.dest;
    assign out_data  = m_q.data;

    always_ff @(posedge clock) begin
        if (reset) begin
            m_v <= 1'b0;
            s_v <= 1'b0;
            m_q <= '0;
            s_q <= '0;
        end else if (flush) begin
            // Only valid bits drop; data fields keep stale contents.
            m_v <= 1'b0;
            s_v <= 1'b0;
        end else if (~m_v | dn_fire) begin
            if (s_v) begin
                // in_ready is low while S is occupied, so nothing new arrives here.
                m_q <= s_q;
                m_v <= 1'b1;
                s_v <= 1'b0;
            end else if (up_fire) begin
                m_q <= in_ent;
                m_v <= 1'b1;
            end else begin
                m_v <= 1'b0;
            end
        end else if (up_fire) begin
            s_q <= in_ent;
            s_v <= 1'b1;
        end
    end

`ifdef PIPE_STAGE_PERF_EN
    // Counters survive flush; only reset clears them.
    always_ff @(posedge clock) begin
        if (reset) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            if (in_valid & ~in_ready & (stall_cnt != 16'hFFFF))
                stall_cnt <= stall_cnt + 16'd1;
            if (~m_v & (bubble_cnt != 16'hFFFF))
                bubble_cnt <= bubble_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// Randomized + directed bench for pipe_stage_skid_reg with a queue-based scoreboard.
// Latency: n/a. Backpressure: out_ready driven randomly and in directed phases.
module tb_pipe_stage_skid_reg;

    logic        clock = 1'b0;
    logic        reset, flush, in_valid, in_ready, out_valid, out_ready;
    logic [3:0]  in_ctrl, out_ctrl;
    logic [4:0]  in_dest, out_dest;
    logic [63:0] in_data, out_data;
`ifdef PIPE_STAGE_PERF_EN
    logic [15:0] stall_cnt, bubble_cnt;
`endif

    pipe_stage_skid_reg dut (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_ctrl(in_ctrl), .in_dest(in_dest), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_ctrl(out_ctrl), .out_dest(out_dest), .out_data(out_data)
`ifdef PIPE_STAGE_PERF_EN
        , .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
`endif
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [3:0]  ctrl;
        logic [4:0]  dest;
        logic [63:0] data;
    } ent_t;

    ent_t q[$];          // entries the stage should currently hold, oldest first
    int   n_cmp = 0;
    int   n_err = 0;
    bit   mon_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: the stage holds at most two entries, is ready whenever it holds
    // fewer than two (outside reset) and shows the oldest entry at its output.
    always @(negedge clock) begin
        if (mon_en) begin
            check("in_ready", {63'd0, in_ready}, {63'd0, (!reset && q.size() < 2)});
            if (q.size() == 0) begin
                check("out_valid_empty", {63'd0, out_valid}, 64'd0);
                check("out_ctrl_gated", {60'd0, out_ctrl}, 64'd0);
            end else begin
                check("out_valid", {63'd0, out_valid}, 64'd1);
                check("out_ctrl", {60'd0, out_ctrl}, {60'd0, q[0].ctrl});
                check("out_dest", {59'd0, out_dest}, {59'd0, q[0].dest});
                check("out_data", out_data, q[0].data);
                if (out_ready) void'(q.pop_front());
            end
        end
    end

    // Stimulus bookkeeping: runs after the monitor so a consumed entry is
    // popped before a flush or reset empties the model.
    always @(negedge clock) begin
        #2;
        if (reset || flush) q.delete();
        else if (in_valid && in_ready) q.push_back('{ctrl: in_ctrl, dest: in_dest, data: in_data});
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] c, input logic [4:0] d, input logic [63:0] x);
        in_valid = v;
        in_ctrl  = c;
        in_dest  = d;
        in_data  = x;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
        drive(1'b1, 4'hF, 5'd9, 64'hDEAD_BEEF_0000_0001);

        // Reset: held for two cycles with a live-looking input.
        step();
        mon_en = 1'b1;
        step();
        @(negedge clock);
        check("rst_out_dest", {59'd0, out_dest}, 64'd0);
        check("rst_out_data", out_data, 64'd0);
        check("rst_in_ready", {63'd0, in_ready}, 64'd0);
        reset = 1'b0;
        drive(1'b0, 4'h0, 5'd0, 64'd0);
        step();

        // Streaming at full rate.
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, 4'(i), 5'(i), {32'hA5A5_0000 + 32'(i), 32'h100 + 32'(i)});
            step();
        end
        drive(1'b0, 4'h0, 5'd0, 64'd0);
        repeat (2) step();

        // Backpressure: A into M, B into skid, then drain.
        out_ready = 1'b0;
        drive(1'b1, 4'h3, 5'd3, 64'hAAAA);
        step();
        drive(1'b1, 4'h4, 5'd4, 64'hBBBB);
        step();
        drive(1'b0, 4'h0, 5'd0, 64'd0);
        repeat (2) step();
        out_ready = 1'b1;
        repeat (3) step();

        // Flush with a full stage while C is presented.
        out_ready = 1'b0;
        drive(1'b1, 4'h1, 5'd1, 64'h1111);
        step();
        drive(1'b1, 4'h2, 5'd2, 64'h2222);
        step();
        drive(1'b1, 4'h7, 5'd7, 64'hCCCC);
        flush = 1'b1;
        step();
        flush = 1'b0;
        drive(1'b0, 4'h0, 5'd0, 64'd0);
        out_ready = 1'b1;
        repeat (3) step();

        // Bubble gating: consumed entry leaves stale data but zero ctrl.
        out_ready = 1'b0;
        drive(1'b1, 4'b0110, 5'd12, 64'h0123_4567_89AB_CDEF);
        step();
        drive(1'b0, 4'h0, 5'd0, 64'd0);
        step();
        out_ready = 1'b1;
        step();
        @(negedge clock);
        check("bubble_data_kept", out_data, 64'h0123_4567_89AB_CDEF);
        check("bubble_ctrl_zero", {60'd0, out_ctrl}, 64'd0);
        check("bubble_valid_zero", {63'd0, out_valid}, 64'd0);

        // Randomized traffic with occasional flush and reset.
        for (int i = 0; i < 2000; i++) begin
            drive(($urandom % 4) != 0, 4'($urandom), 5'($urandom), {$urandom, $urandom});
            out_ready = ($urandom % 3) != 0;
            flush     = ($urandom % 25) == 0;
            reset     = ($urandom % 300) == 0;
            step();
        end
        reset = 1'b0; flush = 1'b0; out_ready = 1'b1;
        drive(1'b0, 4'h0, 5'd0, 64'd0);
        repeat (4) step();
        @(negedge clock);
        check("drained_empty", {63'd0, out_valid}, 64'd0);

`ifdef PIPE_STAGE_PERF_EN
        reset = 1'b1; out_ready = 1'b0;
        repeat (2) step();
        reset = 1'b0;
        step();   // edges 1..2: empty, no input
        step();
        drive(1'b1, 4'h5, 5'd5, 64'h55);
        step();   // edge 3: empty, accept into M
        step();   // edge 4: accept into skid
        repeat (5) step();
        @(negedge clock);
        check("stall_cnt_5", {48'd0, stall_cnt}, 64'd5);
        check("bubble_cnt_3", {48'd0, bubble_cnt}, 64'd3);
        repeat (70000) step();
        @(negedge clock);
        check("stall_cnt_sat", {48'd0, stall_cnt}, 64'hFFFF);
        check("bubble_cnt_hold", {48'd0, bubble_cnt}, 64'd3);
        out_ready = 1'b1;
        drive(1'b0, 4'h0, 5'd0, 64'd0);
        repeat (3) step();
`endif

        mon_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_stage_skid_reg.md
Name: pipe_stage_skid_reg

Overview:
- Parametrised successor to the fixed-field inter-stage pipeline registers; usable at ID/EX, EX/MEM or MEM/WB.
- Carries a control bundle, a destination register index and NUM_WORDS data words between stages.
- Adds a valid/ready handshake backed by a 2-entry skid buffer, plus synchronous flush.
- Control bits are gated to zero whenever the stage holds a bubble, so downstream write enables never fire on invalid entries.

Parameters:
- CTRL_W, 4, width of control bundle (e.g. MemtoReg, RegWrite, MemWrite, MemRead)
- DEST_W, 5, width of destination register index
- DATA_W, 32, width of each data word
- NUM_WORDS, 2, number of data words carried (e.g. ALU result, store value); valid range 1..8

Ports:
- clock  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high
- flush  in  1  synchronous kill of all held entries
- in_valid  in  1  upstream entry valid
- in_ready  out  1  stage can accept an entry
- in_ctrl  in  CTRL_W  upstream control bundle
- in_dest  in  DEST_W  upstream destination index
- in_data  in  NUM_WORDS*DATA_W  upstream data words, word 0 in LSBs
- out_valid  out  1  output entry valid
- out_ready  in  1  downstream accepts the entry
- out_ctrl  out  CTRL_W  control bundle, zero when out_valid=0
- out_dest  out  DEST_W  destination index
- out_data  out  NUM_WORDS*DATA_W  data words

Behaviour:
- Storage: main register M (drives outputs) and skid register S; each has its own valid bit (M_v, S_v).
- Handshakes: up_fire = in_valid & in_ready; dn_fire = out_valid & out_ready.
- in_ready = ~S_v & ~reset. It depends only on registered state, with no combinational path from out_ready.
- out_valid = M_v; out_ctrl = M_ctrl & {CTRL_W{M_v}}; out_dest and out_data are driven directly from M.
- Priority each edge: reset > flush > normal update.
- Normal update, when M is free (~M_v | dn_fire):
  - If S_v: M <= S, S_v <= 0.
  - Else if up_fire: M <= input.
  - Otherwise M_v <= 0.
- Normal update, when M_v & ~dn_fire & up_fire: S <= input, S_v <= 1.
- Because in_ready=0 while S_v=1, no input is taken in a cycle that drains S.
- Latency: 1 cycle from acceptance into an empty stage to out_valid=1.
- Throughput: 1 entry/cycle while out_ready=1. Order is strictly FIFO.
- Full (M_v=S_v=1): in_ready=0; contents hold until out_ready=1.
- Flush: M_v <= 0 and S_v <= 0. Any entry presented with up_fire in the flush cycle is discarded. in_ready=1 and out_valid=0 on the next cycle. Data fields keep their stale values; only the valid bits and gated ctrl change.
- Reset: all registers cleared. Outputs read out_valid=0, out_ctrl=0, out_dest=0, out_data=0; in_ready=0 while reset=1 and 1 on the first cycle after release.
- Reset asserted mid-transfer drops both entries, with no partial update.
- Simultaneous flush and dn_fire: the downstream consumes the current entry in that cycle, then the stage is empty.

Optional Feature:
- Macro: PIPE_STAGE_PERF_EN.
- Defined: adds outputs stall_cnt[15:0] and bubble_cnt[15:0], both reset to 0 and cleared by reset only, not by flush.
  - stall_cnt increments on cycles with in_valid=1 & in_ready=0.
  - bubble_cnt increments on cycles with out_valid=0 & ~reset.
  - Both saturate at 16'hFFFF.
- Undefined: the ports and counters are absent, and the block behaves identically otherwise.

Test Plan:
- Reset: hold reset=1 for 2 cycles with in_valid=1 and in_ctrl=4'hF -> out_valid=0, out_ctrl=0, out_data=0, in_ready=0; in_ready=1 on the first cycle after release.
- Streaming: out_ready=1, inputs dest=1..8 with data0=32'h100+i on consecutive cycles -> outputs in the same order, one cycle later each, no gaps, in_ready stays 1.
- Backpressure: accept A (dest=3), drop out_ready, present B (dest=4) -> B lands in S and in_ready=0 next cycle; raise out_ready -> A then B appear, in_ready=1 after S drains; no entry is lost or duplicated.
- Flush with full stage: flush=1 while in_valid=1 with C -> next cycle out_valid=0, out_ctrl=0, in_ready=1; C never appears at the output.
- Bubble gating: M holds ctrl=4'b0110, then it is consumed with no new input -> out_valid=0 and out_ctrl=0 while out_data retains its old value.
- PIPE_STAGE_PERF_EN build: 5 stalled cycles and 3 empty cycles -> stall_cnt=5, bubble_cnt=3; force 70000 stall cycles -> stall_cnt=16'hFFFF.
